// File: rtl/spi_master_xfer.sv
// spi_master_xfer -- single-byte SPI master, mode 0 (CPOL=0, CPHA=0), MSB first,
// with optional chip-select hold so that several bytes can form one burst.
//
// Parameters
//   CLK_DIV   SPI half-period in clk cycles (1..255)
// Ports
//   clk       system clock, rising edge
//   reset     asynchronous, active-high reset
//   start     request a byte transfer (accepted in IDLE or HELD only)
//   tx_data   byte to send, captured when start is accepted
//   hold      sampled at the last falling sclk edge: 1 keeps cs_n low for a burst
//   busy      transfer or trailing chip-select interval in progress
//   done      one-cycle pulse, rx_data valid
//   rx_data   last received byte
//   sclk      SPI clock, idle low
//   mosi      serial data out
//   miso      serial data in
//   cs_n      active-low chip select
module spi_master_xfer #(
   parameter int CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] tx_data,
   input  logic       hold,
   output logic       busy,
   output logic       done,
   output logic [7:0] rx_data,
   output logic       sclk,
   output logic       mosi,
   input  logic       miso,
   output logic       cs_n
);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HELD, TRAIL} state_t;

   state_t     state_reg, state_next;
   logic [7:0] cnt_reg, cnt_next;
   logic [2:0] bit_reg, bit_next;
   logic [7:0] tx_reg, tx_next;
   logic [7:0] rx_shift_reg, rx_shift_next;
   logic [7:0] rx_data_reg, rx_data_next;
   logic       sclk_reg, sclk_next;
   logic       mosi_reg, mosi_next;
   logic       cs_n_reg, cs_n_next;
   logic       busy_reg, busy_next;
   logic       done_reg, done_next;
   logic       tick;

   // Half-period tick: the counter restarts on every state change, so each
   // state sees its first tick exactly CLK_DIV cycles after entry.
   assign tick = (cnt_reg == 8'(CLK_DIV - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= IDLE;
         cnt_reg      <= 8'd0;
         bit_reg      <= 3'd0;
         tx_reg       <= 8'd0;
         rx_shift_reg <= 8'd0;
         rx_data_reg  <= 8'd0;
         sclk_reg     <= 1'b0;
         mosi_reg     <= 1'b0;
         cs_n_reg     <= 1'b1;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         bit_reg      <= bit_next;
         tx_reg       <= tx_next;
         rx_shift_reg <= rx_shift_next;
         rx_data_reg  <= rx_data_next;
         sclk_reg     <= sclk_next;
         mosi_reg     <= mosi_next;
         cs_n_reg     <= cs_n_next;
         busy_reg     <= busy_next;
         done_reg     <= done_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      bit_next      = bit_reg;
      tx_next       = tx_reg;
      rx_shift_next = rx_shift_reg;
      rx_data_next  = rx_data_reg;
      sclk_next     = sclk_reg;
      mosi_next     = mosi_reg;
      cs_n_next     = cs_n_reg;
      busy_next     = busy_reg;
      done_next     = 1'b0;

      case (state_reg)
         IDLE, HELD: begin
            if (start) begin
               tx_next    = tx_data;
               mosi_next  = tx_data[7];
               cs_n_next  = 1'b0;
               busy_next  = 1'b1;
               bit_next   = 3'd0;
               state_next = SETUP;
            end
         end
         SETUP: begin
            // First rising edge: slave has had one half-period to see bit 7.
            if (tick) begin
               sclk_next     = 1'b1;
               rx_shift_next = {rx_shift_reg[6:0], miso};
               state_next    = SHIFT;
            end
         end
         SHIFT: begin
            if (tick) begin
               if (!sclk_reg) begin
                  sclk_next     = 1'b1;
                  rx_shift_next = {rx_shift_reg[6:0], miso};
               end else begin
                  sclk_next = 1'b0;
                  if (bit_reg == 3'd7) begin
                     // Last falling edge: mosi keeps the final bit.
                     rx_data_next = rx_shift_reg;
                     done_next    = 1'b1;
                     if (hold) begin
                        busy_next  = 1'b0;
                        state_next = HELD;
                     end else begin
                        state_next = TRAIL;
                     end
                  end else begin
                     bit_next  = bit_reg + 3'd1;
                     mosi_next = tx_reg[6];
                     tx_next   = {tx_reg[6:0], 1'b0};
                  end
               end
            end
         end
         TRAIL: begin
            if (tick) begin
               cs_n_next  = 1'b1;
               busy_next  = 1'b0;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase

      if (tick || (state_next != state_reg))
         cnt_next = 8'd0;
      else
         cnt_next = cnt_reg + 8'd1;
   end

   assign busy    = busy_reg;
   assign done    = done_reg;
   assign rx_data = rx_data_reg;
   assign sclk    = sclk_reg;
   assign mosi    = mosi_reg;
   assign cs_n    = cs_n_reg;

endmodule

// File: doc/spi_master_xfer.md
SPI_MASTER_XFER -- requirements
Module: spi_master_xfer

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: SPI half-period in clk cycles, legal range 1..255.
REQ-002 SHALL have input clk, 1 bit: system clock; all state changes on its rising edge.
REQ-003 SHALL have input reset, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have input start, 1 bit: request a byte transfer.
REQ-005 SHALL have input tx_data, 8 bits: byte to send, sampled when start is accepted.
REQ-006 SHALL have input hold, 1 bit: when 1 at end of byte, keep cs_n asserted for a burst.
REQ-007 SHALL have output busy, 1 bit: transfer or trailing chip-select in progress.
REQ-008 SHALL have output done, 1 bit: one-cycle pulse, rx_data valid.
REQ-009 SHALL have output rx_data, 8 bits: last received byte.
REQ-010 SHALL have output sclk, 1 bit: SPI clock, mode 0 (idle low).
REQ-011 SHALL have output mosi, 1 bit: serial data out, MSB first.
REQ-012 SHALL have input miso, 1 bit: serial data in, MSB first.
REQ-013 SHALL have output cs_n, 1 bit: active-low chip select.

Function
REQ-014 SHALL implement states IDLE, SETUP, SHIFT, HELD, TRAIL; all outputs registered.
REQ-015 SHALL generate a half-period tick from a counter running 0..CLK_DIV-1, cleared on each state entry; tick when count = CLK_DIV-1.
REQ-016 IDLE or HELD with start=1 at edge k SHALL latch tx_data, drive mosi=tx_data[7] and cs_n=0, set busy=1, and enter SETUP.
REQ-017 SETUP tick SHALL drive sclk high (first rising edge at clk edge k+CLK_DIV), sample miso, and enter SHIFT.
REQ-018 SHIFT SHALL toggle sclk on every tick; on each rising edge, shift miso into the receive register LSB; on each falling edge except the 8th, present the next tx bit on mosi.
REQ-019 On the 8th falling edge (clk edge k+16*CLK_DIV), the block SHALL load rx_data and pulse done for exactly one cycle; mosi SHALL hold the last bit.
REQ-020 If hold=1 at that edge, the block SHALL enter HELD: cs_n=0, sclk=0, busy=0, waiting for start.
REQ-021 If hold=0 at that edge, the block SHALL enter TRAIL with cs_n=0 and busy=1.
REQ-022 TRAIL tick SHALL set cs_n=1 and busy=0 and enter IDLE, at clk edge k+17*CLK_DIV.
REQ-023 start SHALL be ignored while busy=1; tx_data changes after acceptance SHALL have no effect.
REQ-024 hold SHALL be sampled only at the 8th falling edge; it SHALL have no effect elsewhere.
REQ-025 HELD with hold deasserted and no start SHALL remain in HELD; leaving HELD SHALL require start, with the next byte's hold=0 closing the burst.
REQ-026 sclk SHALL be low whenever state is IDLE, HELD, TRAIL, or SETUP.
REQ-027 rx_data SHALL hold its value between done pulses.
REQ-028 With CLK_DIV=1, sclk SHALL toggle every clk cycle with identical sequencing.

Reset
REQ-029 While reset=1, outputs SHALL be immediately: cs_n=1, sclk=0, mosi=0, busy=0, done=0, rx_data=8'h00; state=IDLE; counters and shift registers cleared.
REQ-030 Reset asserted mid-transfer SHALL abort without a done pulse; the first start after release SHALL begin a clean transfer.

Verification
REQ-031 CLK_DIV=2, tx_data=8'hA5, miso looped to mosi -> mosi bits 1,0,1,0,0,1,0,1 on 8 rising edges; done at start+32 cycles; rx_data=8'hA5; cs_n high at start+34.
REQ-032 CLK_DIV=1, miso tied 1, tx_data=8'h00 -> rx_data=8'hFF; exactly 8 sclk pulses; done width 1 cycle.
REQ-033 Burst: hold=1 on bytes 8'h12 and 8'h34, hold=0 on 8'h56 -> cs_n low continuously across all 3 bytes; 3 done pulses; cs_n high one half-period after the 3rd.
REQ-034 Second start pulsed while busy -> ignored; only one done; exactly 8 sclk rising edges.
REQ-035 Reset asserted after 3rd rising edge -> same-cycle cs_n=1, sclk=0, no done; next transfer of 8'h3C with loopback gives rx_data=8'h3C.
REQ-036 Model-based check against an ideal mode-0 slave model with random tx/miso bytes and CLK_DIV in {1,3,7} -> all rx_data match, sclk idle low, no glitches on cs_n mid-byte.
